axis_packet_arbiter: RTL and testbench

- Packet-granular round-robin arbiter that merges NUM_PORTS AXI-stream inputs onto one AXI-stream output.
- Each input is normally driven by an axis_packet_fifo, which only presents complete, already-validated packets.
- Once a port is granted, the grant stays locked until that packet's tlast handshake, so packets from different ports are never interleaved.
- Sits between the per-ingress packet FIFOs and the shared egress path of the packet router.

---
 rtl/axis_packet_arbiter_if.sv | 29 ++
 rtl/axis_packet_arbiter.sv | 106 ++++++++++
 tb/tb_axis_packet_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/axis_packet_arbiter_if.sv
// AXI-stream bundle for the packet arbiter: NUM_PORTS ingress streams
// merged onto one egress stream. The master modport is the arbiter's view;
// slave is the surrounding environment (upstream FIFOs plus downstream sink).
interface axis_packet_arbiter_if #(
  parameter int NUM_PORTS   = 4,
  parameter int TDATA_WIDTH = 32
);
  localparam int ID_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS*TDATA_WIDTH-1:0] s_axis_tdata;
  logic [NUM_PORTS-1:0]             s_axis_tlast;
  logic [NUM_PORTS-1:0]             s_axis_tvalid;
  logic [NUM_PORTS-1:0]             s_axis_tready;
  logic [TDATA_WIDTH-1:0]           m_axis_tdata;
  logic                             m_axis_tlast;
  logic                             m_axis_tvalid;
  logic                             m_axis_tready;
  logic [ID_WIDTH-1:0]              m_axis_tid;

  modport master (
    input  s_axis_tdata, s_axis_tlast, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tvalid, m_axis_tid
  );

  modport slave (
    output s_axis_tdata, s_axis_tlast, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tlast, m_axis_tvalid, m_axis_tid
  );
endinterface

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter. A grant is locked from the first beat
// until the tlast handshake, so packets never interleave. One dead cycle in
// IDLE separates consecutive packets; the port that just finished gets the
// lowest priority in the next arbitration.
module axis_packet_arbiter #(
  parameter int  NUM_PORTS   = 4,
  parameter int  TDATA_WIDTH = 32,
  localparam int ID_WIDTH    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  axis_packet_arbiter_if.master bus,
  output logic                  busy,
  output logic [15:0]           pkt_count
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [ID_WIDTH-1:0] LAST_PORT = ID_WIDTH'(NUM_PORTS - 1);

  state_t              state;
  logic [ID_WIDTH-1:0] grant;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] tid_q;
  logic [ID_WIDTH-1:0] hi_idx;
  logic [ID_WIDTH-1:0] lo_idx;
  logic [ID_WIDTH-1:0] sel_idx;
  logic                hi_found;
  logic                any_valid;
  logic                pkt_end;

  // Round-robin pick: lowest requesting port at or above rr_ptr, else wrap
  // to the lowest requesting port overall. Descending scan keeps the lowest.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (bus.s_axis_tvalid[i]) begin
        lo_idx = ID_WIDTH'(i);
        if (ID_WIDTH'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = ID_WIDTH'(i);
        end
      end
    end
    any_valid = |bus.s_axis_tvalid;
    sel_idx   = hi_found ? hi_idx : lo_idx;
  end

  // Combinational pass-through of the granted port while in GRANT.
  always_comb begin
    bus.m_axis_tdata  = '0;
    bus.m_axis_tlast  = 1'b0;
    bus.m_axis_tvalid = 1'b0;
    bus.s_axis_tready = '0;
    if (state == GRANT) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant == ID_WIDTH'(i)) begin
          bus.m_axis_tdata  = bus.s_axis_tdata[i*TDATA_WIDTH +: TDATA_WIDTH];
          bus.m_axis_tlast  = bus.s_axis_tlast[i];
          bus.m_axis_tvalid = bus.s_axis_tvalid[i];
          bus.s_axis_tready[i] = bus.m_axis_tready;
        end
      end
    end
  end

  assign pkt_end        = (state == GRANT) & bus.m_axis_tvalid &
                          bus.m_axis_tready & bus.m_axis_tlast;
  assign bus.m_axis_tid = tid_q;

  // Arbitration FSM with registered busy/tid and the forwarded-packet counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      tid_q     <= '0;
      busy      <= 1'b0;
      pkt_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            state <= GRANT;
            grant <= sel_idx;
            tid_q <= sel_idx;
            busy  <= 1'b1;
          end
        end
        GRANT: begin
          if (pkt_end) begin
            state     <= IDLE;
            rr_ptr    <= (grant == LAST_PORT) ? '0 : grant + ID_WIDTH'(1);
            pkt_count <= pkt_count + 16'd1;
            tid_q     <= '0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench for axis_packet_arbiter (4 ports, 32-bit data): a vector
// table for single-packet, lock, backpressure and single-beat cycles, then
// hand-written sequences for round-robin order, counter wrap and reset.
module tb_axis_packet_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic [15:0] pkt_count;

  axis_packet_arbiter_if #(.NUM_PORTS(4), .TDATA_WIDTH(32)) bus ();

  axis_packet_arbiter #(.NUM_PORTS(4), .TDATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mrdy;
    logic [3:0]  vld;
    logic [3:0]  last;
    logic [31:0] db;      // one data byte per port, port p in db[p*8 +: 8]
    logic        e_mv;
    logic        e_ml;
    logic [7:0]  e_d;
    logic [1:0]  e_tid;
    logic [3:0]  e_srdy;
    logic        e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  int checks = 0;
  int errors = 0;

  logic [56:0] act_v, exp_v;
  logic [3:0]  beat;
  int          npk [4];
  int          exp_order [6];
  int          pkts, hp, t;
  bit          after_last, expect_first, hs;

  function automatic vec_t mk(input logic mrdy, input logic [3:0] vld,
                              input logic [3:0] last, input logic [31:0] db,
                              input logic e_mv, input logic e_ml,
                              input logic [7:0] e_d, input logic [1:0] e_tid,
                              input logic [3:0] e_srdy, input logic e_busy,
                              input logic [15:0] e_cnt);
    vec_t v;
    v = '{mrdy, vld, last, db, e_mv, e_ml, e_d, e_tid, e_srdy, e_busy, e_cnt};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic drive(input logic mrdy, input logic [3:0] vld,
                       input logic [3:0] last, input logic [31:0] db);
    bus.m_axis_tready = mrdy;
    bus.s_axis_tvalid = vld;
    bus.s_axis_tlast  = last;
    for (int p = 0; p < 4; p++)
      bus.s_axis_tdata[p*32 +: 32] = {24'h0, db[p*8 +: 8]};
  endtask

  function automatic logic [31:0] rr_word(input int p);
    return {16'h0, 8'(p), 7'(npk[p]), beat[p]};
  endfunction

  task automatic rr_drive();
    bus.m_axis_tready = 1'b1;
    bus.s_axis_tvalid = 4'b1111;
    for (int p = 0; p < 4; p++) begin
      bus.s_axis_tlast[p] = beat[p];
      bus.s_axis_tdata[p*32 +: 32] = rr_word(p);
    end
  endtask

  initial begin
    //        mrdy vld      last     db            mv   ml   d      tid   srdy     busy cnt
    vecs[0]  = mk(1, 4'b0000, 4'b0000, 32'h00000000, 0, 0, 8'h00, 2'd0, 4'b0000, 0, 16'd0);
    vecs[1]  = mk(1, 4'b0100, 4'b0000, 32'h00A00000, 0, 0, 8'h00, 2'd0, 4'b0000, 0, 16'd0);
    vecs[2]  = mk(1, 4'b0100, 4'b0000, 32'h00A00000, 1, 0, 8'hA0, 2'd2, 4'b0100, 1, 16'd0);
    vecs[3]  = mk(1, 4'b0100, 4'b0000, 32'h00A10000, 1, 0, 8'hA1, 2'd2, 4'b0100, 1, 16'd0);
    vecs[4]  = mk(1, 4'b0100, 4'b0100, 32'h00A20000, 1, 1, 8'hA2, 2'd2, 4'b0100, 1, 16'd0);
    vecs[5]  = mk(1, 4'b0000, 4'b0000, 32'h00000000, 0, 0, 8'h00, 2'd0, 4'b0000, 0, 16'd1);
    vecs[6]  = mk(1, 4'b0001, 4'b0000, 32'h000000B0, 0, 0, 8'h00, 2'd0, 4'b0000, 0, 16'd1);
    vecs[7]  = mk(1, 4'b0001, 4'b0000, 32'h000000B0, 1, 0, 8'hB0, 2'd0, 4'b0001, 1, 16'd1);
    vecs[8]  = mk(1, 4'b0011, 4'b0000, 32'h0000C0B1, 1, 0, 8'hB1, 2'd0, 4'b0001, 1, 16'd1);
    vecs[9]  = mk(1, 4'b0011, 4'b0000, 32'h0000C0B2, 1, 0, 8'hB2, 2'd0, 4'b0001, 1, 16'd1);
    vecs[10] = mk(1, 4'b0011, 4'b0000, 32'h0000C0B3, 1, 0, 8'hB3, 2'd0, 4'b0001, 1, 16'd1);
    vecs[11] = mk(1, 4'b0011, 4'b0001, 32'h0000C0B4, 1, 1, 8'hB4, 2'd0, 4'b0001, 1, 16'd1);
    vecs[12] = mk(1, 4'b0010, 4'b0000, 32'h0000C000, 0, 0, 8'h00, 2'd0, 4'b0000, 0, 16'd2);
    vecs[13] = mk(1, 4'b0010, 4'b0000, 32'h0000C000, 1, 0, 8'hC0, 2'd1, 4'b0010, 1, 16'd2);
    vecs[14] = mk(0, 4'b0010, 4'b0000, 32'h0000C100, 1, 0, 8'hC1, 2'd1, 4'b0000, 1, 16'd2);
    vecs[15] = mk(0, 4'b0010, 4'b0000, 32'h0000C100, 1, 0, 8'hC1, 2'd1, 4'b0000, 1, 16'd2);
    vecs[16] = mk(1, 4'b0010, 4'b0000, 32'h0000C100, 1, 0, 8'hC1, 2'd1, 4'b0010, 1, 16'd2);
    vecs[17] = mk(1, 4'b0001, 4'b0000, 32'h000000D0, 0, 0, 8'h00, 2'd1, 4'b0010, 1, 16'd2);
    vecs[18] = mk(1, 4'b0011, 4'b0010, 32'h0000C2D0, 1, 1, 8'hC2, 2'd1, 4'b0010, 1, 16'd2);
    vecs[19] = mk(1, 4'b0001, 4'b0001, 32'h000000D0, 0, 0, 8'h00, 2'd0, 4'b0000, 0, 16'd3);
    vecs[20] = mk(1, 4'b0001, 4'b0001, 32'h000000D0, 1, 1, 8'hD0, 2'd0, 4'b0001, 1, 16'd3);
    vecs[21] = mk(1, 4'b0000, 4'b0000, 32'h00000000, 0, 0, 8'h00, 2'd0, 4'b0000, 0, 16'd4);

    exp_order = '{0, 1, 2, 3, 0, 1};

    // Power-on reset
    reset = 1'b1;
    drive(1'b0, 4'b0000, 4'b0000, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Vector table
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].mrdy, vecs[i].vld, vecs[i].last, vecs[i].db);
      @(negedge clk);
      act_v = {bus.m_axis_tvalid, bus.m_axis_tvalid & bus.m_axis_tlast,
               bus.m_axis_tvalid ? bus.m_axis_tdata : 32'h0,
               bus.m_axis_tid, bus.s_axis_tready, busy, pkt_count};
      exp_v = {vecs[i].e_mv, vecs[i].e_ml,
               vecs[i].e_mv ? {24'h0, vecs[i].e_d} : 32'h0,
               vecs[i].e_tid, vecs[i].e_srdy, vecs[i].e_busy, vecs[i].e_cnt};
      check($sformatf("vec%0d", i), 64'(act_v), 64'(exp_v));
      @(posedge clk); #1;
    end

    // Round-robin: all ports continuously offer 2-beat packets, from reset
    reset = 1'b1;
    #1 check("rr_reset_cnt", 64'(pkt_count), 64'(16'd0));
    @(posedge clk); #1 reset = 1'b0;
    beat = '0;
    for (int p = 0; p < 4; p++) npk[p] = 0;
    pkts = 0; after_last = 0; expect_first = 0;
    for (int cyc = 0; cyc < 80 && pkts < 6; cyc++) begin
      rr_drive();
      @(negedge clk);
      hs = 0;
      if (after_last) begin
        check("rr_gap", 64'(bus.m_axis_tvalid), 64'(1'b0));
        after_last = 0;
        expect_first = 1;
      end else if (expect_first) begin
        check("rr_resume", 64'(bus.m_axis_tvalid), 64'(1'b1));
        expect_first = 0;
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        t = int'(bus.m_axis_tid);
        if (!beat[t]) check($sformatf("rr_order%0d", pkts), 64'(t), 64'(exp_order[pkts]));
        check("rr_data", 64'(bus.m_axis_tdata), 64'(rr_word(t)));
        check("rr_last", 64'(bus.m_axis_tlast), 64'(beat[t]));
        hs = 1; hp = t;
      end
      @(posedge clk); #1;
      if (hs) begin
        if (beat[hp]) begin
          npk[hp]++;
          pkts++;
          after_last = 1;
        end
        beat[hp] = ~beat[hp];
      end
    end
    drive(1'b1, 4'b0000, 4'b0000, 32'h0);
    check("rr_pkts_done", 64'(pkts), 64'(6));
    @(negedge clk);
    check("rr_cnt", 64'(pkt_count), 64'(16'd6));

    // Counter wrap: preload near the top, then two single-beat packets
    @(posedge clk); #1;
    force dut.pkt_count = 16'hFFFE;
    @(posedge clk); #1;
    release dut.pkt_count;
    @(negedge clk);
    check("wrap_preload", 64'(pkt_count), 64'(16'hFFFE));
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      drive(1'b1, 4'b0001, 4'b0001, 32'h000000E0);
      @(posedge clk); #1;
      @(negedge clk);
      check("wrap_beat", 64'({bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata}),
            64'({1'b1, 1'b1, 32'h000000E0}));
      @(posedge clk); #1;
      drive(1'b1, 4'b0000, 4'b0000, 32'h0);
      @(negedge clk);
      check($sformatf("wrap_cnt%0d", k), 64'(pkt_count), 64'(k == 0 ? 16'hFFFF : 16'h0000));
    end

    // Reset mid-packet on beat 2 of a 4-beat packet from port 1
    @(posedge clk); #1;
    drive(1'b1, 4'b0010, 4'b0000, 32'h0000E000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(1'b1, 4'b0010, 4'b0000, 32'h0000E100);
    @(negedge clk);
    check("mid_pre", 64'({bus.m_axis_tvalid, bus.m_axis_tdata, bus.s_axis_tready}),
          64'({1'b1, 32'h000000E1, 4'b0010}));
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("mid_rst_mv", 64'(bus.m_axis_tvalid), 64'(1'b0));
    check("mid_rst_srdy", 64'(bus.s_axis_tready), 64'(4'b0000));
    check("mid_rst_state", 64'({busy, bus.m_axis_tid, pkt_count}), 64'({1'b0, 2'd0, 16'd0}));
    @(posedge clk); #1 reset = 1'b0;
    drive(1'b1, 4'b1111, 4'b1111, 32'hF3F2F1F0);
    @(negedge clk);
    check("post_idle", 64'(bus.m_axis_tvalid), 64'(1'b0));
    @(posedge clk); #1;
    @(negedge clk);
    check("post_all", 64'({bus.m_axis_tvalid, bus.m_axis_tid, bus.m_axis_tdata}),
          64'({1'b1, 2'd0, 32'h000000F0}));
    @(posedge clk); #1;
    drive(1'b1, 4'b1000, 4'b1000, 32'h30000000);
    @(negedge clk);
    check("post_gap", 64'(bus.m_axis_tvalid), 64'(1'b0));
    @(posedge clk); #1;
    @(negedge clk);
    check("post_p3", 64'({bus.m_axis_tvalid, bus.m_axis_tid, bus.m_axis_tdata, bus.s_axis_tready}),
          64'({1'b1, 2'd3, 32'h00000030, 4'b1000}));
    @(posedge clk); #1;
    drive(1'b1, 4'b0000, 4'b0000, 32'h0);
    @(negedge clk);
    check("post_cnt", 64'({busy, pkt_count}), 64'({1'b0, 16'd2}));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
